// File: rtl/aes_key_schedule_if.sv
// Handshake and read-port bundle for the AES-128 key schedule.
// The master side drives start/key/rd_addr. The slave side (the key schedule) returns status and round keys.
interface aes_key_schedule_if;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         ready;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;

    modport master (output start, key, rd_addr, input busy, ready, rd_key);
    modport slave  (input start, key, rd_addr, output busy, ready, rd_key);
endinterface

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: one expandKey round per clock.
// It fills an 11-entry round-key file. The file is read through a registered port.
module aes_key_schedule #(
    parameter int ROUNDS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_key_schedule_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   count_q, count_d;
    logic [127:0] slot_q [0:ROUNDS];
    logic [127:0] slot_d [0:ROUNDS];
    logic [127:0] rd_key_q, rd_key_d;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (a^254, with 0 mapping to 0), then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [7:0] rnd);
        logic [7:0] rc;
        case (rnd)
            8'd1:    rc = 8'h01;
            8'd2:    rc = 8'h02;
            8'd3:    rc = 8'h04;
            8'd4:    rc = 8'h08;
            8'd5:    rc = 8'h10;
            8'd6:    rc = 8'h20;
            8'd7:    rc = 8'h40;
            8'd8:    rc = 8'h80;
            8'd9:    rc = 8'h1b;
            8'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One AES-128 expansion round. Word 0 is in[127:96].
    function automatic logic [127:0] expand_key(input logic [127:0] in, input logic [7:0] rnd);
        logic [31:0] t, o0, o1, o2, o3;
        t  = {sbox(in[23:16]), sbox(in[15:8]), sbox(in[7:0]), sbox(in[31:24])}
             ^ {rcon(rnd), 24'h000000};
        o0 = in[127:96] ^ t;
        o1 = in[95:64]  ^ o0;
        o2 = in[63:32]  ^ o1;
        o3 = in[31:0]   ^ o2;
        return {o0, o1, o2, o3};
    endfunction

    // Next state, round counter and key-file writes. The read port samples the pre-write contents.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        slot_d  = slot_q;
        rd_key_d = (bus.rd_addr <= 4'(ROUNDS)) ? slot_q[bus.rd_addr] : '0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    slot_d[0] = bus.key;
                    count_d   = 4'd1;
                    state_d   = EXPAND;
                end
            end
            EXPAND: begin
                slot_d[count_q] = expand_key(slot_q[count_q - 4'd1], {4'd0, count_q});
                if (count_q == 4'(ROUNDS)) begin
                    count_d = 4'd0;
                    state_d = DONE;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, key file and read register. Reset clears all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= 4'd0;
            rd_key_q <= '0;
            for (int i = 0; i <= ROUNDS; i++) slot_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_key_q <= rd_key_d;
            for (int i = 0; i <= ROUNDS; i++) slot_q[i] <= slot_d[i];
        end
    end

    // Status is decoded from the registered state, so busy and ready can never both be high
    assign bus.busy   = (state_q == EXPAND);
    assign bus.ready  = (state_q == DONE);
    assign bus.rd_key = rd_key_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: known-answer table, random keys against a
// table-based FIPS-197 model, plus restart/reset/read-collision sequences.
module tb_aes_key_schedule;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_key_schedule_if bus();
    aes_key_schedule dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] s1;
        logic [127:0] s10;
    } vec_t;
    vec_t vecs [2];

    logic [7:0]   sb [256];
    logic [127:0] model_rk [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_S10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    // S-box from the generator walk over GF(2^8) (powers of 3 and their inverses)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    // FIPS-197 word-wise expansion into 44 words
    task automatic compute_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Pulse start for one edge; returns 1ns after the accepting edge T
    task automatic start_key(input logic [127:0] k);
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = k;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until ready; bounded so a stuck DUT shows as a wrong count
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            chk("busy_and_ready", {127'd0, bus.busy & bus.ready}, 128'd0);
        end while (!bus.ready && n < 30);
    endtask

    task automatic rd(input logic [3:0] a, output logic [127:0] d);
        @(negedge clk);
        bus.rd_addr = a;
        @(posedge clk);
        #1;
        d = bus.rd_key;
    endtask

    task automatic check_all(input string tag);
        logic [127:0] d;
        for (int i = 0; i < 11; i++) begin
            rd(4'(i), d);
            chk($sformatf("%s_slot%0d", tag, i), d, model_rk[i]);
        end
    endtask

    initial begin
        int n;
        logic [127:0] d, k, old3;

        vecs[0] = '{FIPS_KEY, 128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{128'd0,   128'h62636363626363636263636362636363, ZERO_S10};
        build_sbox();

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.key = '0;
        bus.rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {127'd0, bus.busy}, 128'd0);
        chk("rst_ready", {127'd0, bus.ready}, 128'd0);
        chk("rst_rd_key", bus.rd_key, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(4'd0, d);
        chk("rst_slot0", d, 128'd0);

        // Known-answer table
        foreach (vecs[v]) begin
            start_key(vecs[v].key);
            chk($sformatf("v%0d_busy", v), {127'd0, bus.busy}, 128'd1);
            chk($sformatf("v%0d_ready_low", v), {127'd0, bus.ready}, 128'd0);
            wait_ready(n);
            chk($sformatf("v%0d_latency", v), 128'(n), 128'd10);
            chk($sformatf("v%0d_busy_done", v), {127'd0, bus.busy}, 128'd0);
            rd(4'd0, d);  chk($sformatf("v%0d_slot0", v), d, vecs[v].key);
            rd(4'd1, d);  chk($sformatf("v%0d_slot1", v), d, vecs[v].s1);
            rd(4'd10, d); chk($sformatf("v%0d_slot10", v), d, vecs[v].s10);
            if (v == 1) begin
                for (int a = 11; a < 16; a++) begin
                    rd(4'(a), d);
                    chk($sformatf("oob_addr%0d", a), d, 128'd0);
                end
            end
        end

        // Random keys against the model
        for (int r = 0; r < 4; r++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            compute_model(k);
            start_key(k);
            wait_ready(n);
            chk($sformatf("rnd%0d_latency", r), 128'(n), 128'd10);
            check_all($sformatf("rnd%0d", r));
        end

        // start during EXPAND (sampled at edge T+4) is ignored
        compute_model(FIPS_KEY);
        start_key(FIPS_KEY);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.key = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ign_busy", {127'd0, bus.busy}, 128'd1);
        wait_ready(n);
        chk("ign_latency", 128'(n), 128'd6);
        check_all("ign");

        // Reset in the middle of an expansion
        start_key(128'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {127'd0, bus.busy}, 128'd0);
        chk("mid_rst_ready", {127'd0, bus.ready}, 128'd0);
        chk("mid_rst_rd_key", bus.rd_key, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            rd(4'(i), d);
            chk($sformatf("post_rst_slot%0d", i), d, 128'd0);
        end
        chk("post_rst_ready", {127'd0, bus.ready}, 128'd0);
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        compute_model(k);
        start_key(k);
        wait_ready(n);
        chk("post_rst_latency", 128'(n), 128'd10);
        check_all("post_rst");

        // Back-to-back restarts from DONE
        start_key(FIPS_KEY);
        chk("rs1_ready_drop", {127'd0, bus.ready}, 128'd0);
        wait_ready(n);
        chk("rs1_latency", 128'(n), 128'd10);
        start_key(128'd0);
        chk("rs2_ready_drop", {127'd0, bus.ready}, 128'd0);
        wait_ready(n);
        chk("rs2_latency", 128'(n), 128'd10);
        rd(4'd10, d);
        chk("rs2_slot10", d, ZERO_S10);

        // Hold rd_addr=3 through an expansion: the old value is kept until edge T+3
        compute_model(128'd0);
        old3 = model_rk[3];
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        compute_model(k);
        @(negedge clk);
        bus.rd_addr = 4'd3;
        start_key(k);
        chk("rbw_edge0", bus.rd_key, old3);
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rbw_edge%0d", e), bus.rd_key, (e <= 3) ? old3 : model_rk[3]);
        end
        wait_ready(n);
        chk("rbw_latency", 128'(n + 5), 128'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential AES-128 key schedule. On `start` it latches a 128-bit cipher key and iterates the team's `expandKey` round function once per clock, producing round keys 1..10. All eleven round keys (0..10) are stored in an internal register file. The cipher datapath downstream reads them by round index through a registered read port.

## Interface

Parameters:
- `ROUNDS`, 10, number of expansion rounds; fixed at 10 for AES-128, not to be overridden.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  one-cycle pulse; begins a new expansion of `key`.
- `key`  input  128  cipher key, sampled only in the cycle `start` is accepted.
- `busy`  output  1  high while expansion is in progress.
- `ready`  output  1  high once all 11 round keys are valid.
- `rd_addr`  input  4  round-key index 0..15.
- `rd_key`  output  128  registered round key for `rd_addr`.

## Operation

- FSM states: IDLE, EXPAND, DONE.
  - IDLE: `start` moves to EXPAND.
  - EXPAND: `count` advances each cycle; moves to DONE after slot 10 is written.
  - DONE: `start` restarts and moves to EXPAND.
- Reset state: IDLE; `busy`=0, `ready`=0, `rd_key`=0, `count`=0, all 11 slots=0.
- Start acceptance:
  - `start` is accepted in IDLE or DONE.
  - On acceptance: slot0 <= `key`, `count` <= 1, state <= EXPAND, `ready` <= 0, `busy` <= 1.
  - `start` during EXPAND is ignored; `key` is not sampled and the sequence continues undisturbed.
- Each EXPAND cycle:
  - `expandKey` is driven with in = slot[count-1] and count = `count`, using the 8-bit round index 1..10.
  - The instantiated rcon must map 1..10 to 01,02,04,08,10,20,40,80,1b,36 in the top byte.
  - slot[count] <= result; `count` <= `count`+1.
- When `count`=10 is written:
  - state <= DONE, `busy` <= 0, `ready` <= 1, `count` <= 0.
- Slots 1..10 are written only by the FSM. Slot 0 is written only on start acceptance.
- Read port:
  - `rd_key` <= slot[`rd_addr`] every cycle, independent of state.
  - `rd_addr` 11..15 returns all-zero.
- Read/write collision on the same slot in the same cycle: `rd_key` returns the pre-write contents (read-before-write).
- Reset mid-operation: immediate return to reset state. A partial schedule is discarded and `ready` stays 0 until a full expansion completes.

## Timing

- `start` sampled high at edge T (state IDLE/DONE): slot0 valid after T; `busy`=1 after T.
- Slot k (1..10) valid after edge T+k.
- `busy`=0 and `ready`=1 after edge T+10, i.e. ten cycles after acceptance.
- A new `start` is accepted no earlier than edge T+11.
- Read latency is one cycle: `rd_addr` applied before edge E gives `rd_key` valid after E.
- Back-to-back restart: `start` in the first DONE cycle drops `ready` after that edge. Old slots 1..10 stay readable until overwritten, but are stale.
- `ready` and `busy` are never high simultaneously.

## Test plan

- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - `start` -> `ready` rises exactly 10 cycles later.
  - Slot1 = a0fafe1788542cb123a339392a6c7605.
  - Slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Slot0 = the input key.
- All-zero key:
  - Slot1 = 62636363626363636263636362636363.
  - Slot10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - `rd_addr`=11..15 -> `rd_key`=0.
- `start` with a different key pulsed at EXPAND cycle 4 -> ignored. Schedule matches the original key; `ready` timing is unchanged.
- `rst_n` low at EXPAND cycle 5, then `start` after release:
  - During reset: `busy`=`ready`=0 and all slots read 0.
  - After release: the new expansion completes correctly in 10 cycles.
- From DONE, `start` with FIPS key then with zero key:
  - `ready` drops the cycle after `start`.
  - Final slot10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Hold `rd_addr`=3 through an expansion:
  - `rd_key` shows the old slot3 through edge T+3.
  - It shows the new slot3 from edge T+4 onward, confirming read-before-write.
